// File: rtl/tt_scan.sv
// Truth-table scanner: steps {a,b,c} through 0..7, holds each for DWELL cycles,
// captures y into table_out and compares it against a latched golden pattern.
module tt_scan #(
    parameter int unsigned DWELL = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       pass
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [7:0] DwellLast = 8'(DWELL - 1);

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] dwell_q, dwell_d;
    logic [7:0] table_q, table_d;
    logic [7:0] exp_q, exp_d;
    logic       pass_q, pass_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        table_d = table_q;
        exp_d   = exp_q;
        pass_d  = pass_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    idx_d   = 3'd0;
                    dwell_d = 8'd0;
                    table_d = 8'h00;
                    exp_d   = expected;
                    pass_d  = 1'b0;
                end
            end
            StRun: begin
                if (dwell_q != DwellLast) begin
                    dwell_d = dwell_q + 8'd1;
                end else begin
                    dwell_d        = 8'd0;
                    table_d[idx_q] = y;
                    if (idx_q == 3'd7) begin
                        // Compare against the table including the bit captured this edge
                        state_d = StDone;
                        pass_d  = (table_d == exp_q);
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= 3'd0;
            dwell_q <= 8'd0;
            table_q <= 8'h00;
            exp_q   <= 8'h00;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            table_q <= table_d;
            exp_q   <= exp_d;
            pass_q  <= pass_d;
        end
    end

    assign {a, b, c}  = (state_q == StRun) ? idx_q : 3'b000;
    assign busy       = (state_q == StRun);
    assign done       = (state_q == StDone);
    assign table_out  = table_q;
    assign pass       = pass_q;

endmodule

// File: tb/tb_tt_scan.sv
// Directed bench for tt_scan: one instance at DWELL=2 driven by a mux-style SOP,
// one at DWELL=1 driven by a 3-input parity function.
module tb_tt_scan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start2, start1;
    logic [7:0] exp2, exp1;
    logic       a2, b2, c2, busy2, done2, pass2;
    logic       a1, b1, c1, busy1, done1, pass1;
    logic [7:0] tab2, tab1;
    logic       y2, y1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign y2 = (a2 & b2) | (~a2 & c2);
    assign y1 = a1 ^ b1 ^ c1;

    tt_scan #(.DWELL(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start2),
        .expected  (exp2),
        .y         (y2),
        .a         (a2),
        .b         (b2),
        .c         (c2),
        .busy      (busy2),
        .done      (done2),
        .table_out (tab2),
        .pass      (pass2)
    );

    tt_scan #(.DWELL(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start1),
        .expected  (exp1),
        .y         (y1),
        .a         (a1),
        .b         (b1),
        .c         (c1),
        .busy      (busy1),
        .done      (done1),
        .table_out (tab1),
        .pass      (pass1)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] req);
        n_vec++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic check_quiet2(input string tag);
        check({tag, "_abc"}, {5'd0, a2, b2, c2}, 8'd0);
        check({tag, "_busy"}, {7'd0, busy2}, 8'd0);
        check({tag, "_done"}, {7'd0, done2}, 8'd0);
        check({tag, "_pass"}, {7'd0, pass2}, 8'd0);
        check({tag, "_table"}, tab2, 8'h00);
    endtask

    // Called at the first negedge after the accepting edge; walks all 16 run cycles.
    task automatic run2(input int pulse_at);
        for (int j = 0; j < 16; j++) begin
            check("run2_busy", {7'd0, busy2}, 8'd1);
            check("run2_done", {7'd0, done2}, 8'd0);
            check("run2_abc", {5'd0, a2, b2, c2}, 8'(j / 2));
            if (j == pulse_at) start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
        end
    endtask

    task automatic launch2(input logic [7:0] e);
        start2 = 1'b1;
        exp2   = e;
        @(negedge clk);
        start2 = 1'b0;
        exp2   = ~e;
    endtask

    task automatic check_done2(input logic [7:0] tab, input logic p);
        check("end2_busy", {7'd0, busy2}, 8'd0);
        check("end2_done", {7'd0, done2}, 8'd1);
        check("end2_abc", {5'd0, a2, b2, c2}, 8'd0);
        check("end2_table", tab2, tab);
        check("end2_pass", {7'd0, pass2}, {7'd0, p});
    endtask

    initial begin
        rst_n  = 1'b0;
        start2 = 1'b0;
        start1 = 1'b0;
        exp2   = 8'h00;
        exp1   = 8'h00;

        // Reset held 3 cycles, then idle 5 cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_quiet2("rst");
            check("rst_busy1", {7'd0, busy1}, 8'd0);
            check("rst_table1", tab1, 8'h00);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_quiet2("idle");
        end

        // Golden pass
        launch2(8'hCA);
        run2(-1);
        check_done2(8'hCA, 1'b1);
        @(negedge clk);
        check("hold_done", {7'd0, done2}, 8'd1);
        check("hold_table", tab2, 8'hCA);
        check("hold_pass", {7'd0, pass2}, 8'd1);

        // Mismatch
        launch2(8'hCB);
        run2(-1);
        check_done2(8'hCA, 1'b0);

        // Start pulse mid-run is ignored; completion timing unchanged
        launch2(8'h11);
        run2(5);
        check_done2(8'hCA, 1'b0);

        // Restart from DONE with start held: done lasts one cycle, expected re-latched
        start2 = 1'b1;
        exp2   = 8'hCA;
        @(negedge clk);
        start2 = 1'b0;
        exp2   = 8'h00;
        check("rs_done", {7'd0, done2}, 8'd0);
        check("rs_busy", {7'd0, busy2}, 8'd1);
        check("rs_table", tab2, 8'h00);
        check("rs_pass", {7'd0, pass2}, 8'd0);
        run2(-1);
        check_done2(8'hCA, 1'b1);

        // Reset mid-scan at idx 4
        launch2(8'hCA);
        for (int j = 0; j < 8; j++) @(negedge clk);
        check("mid_abc", {5'd0, a2, b2, c2}, 8'd4);
        check("mid_table", tab2, 8'h0A);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_quiet2("midrst");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_done", {7'd0, done2}, 8'd0);
            check("post_busy", {7'd0, busy2}, 8'd0);
        end
        launch2(8'hCA);
        run2(-1);
        check_done2(8'hCA, 1'b1);

        // DWELL=1 parity scan
        start1 = 1'b1;
        exp1   = 8'h96;
        @(negedge clk);
        start1 = 1'b0;
        exp1   = 8'h00;
        for (int j = 0; j < 8; j++) begin
            check("d1_busy", {7'd0, busy1}, 8'd1);
            check("d1_abc", {5'd0, a1, b1, c1}, 8'(j));
            @(negedge clk);
        end
        check("d1_busy_end", {7'd0, busy1}, 8'd0);
        check("d1_done", {7'd0, done1}, 8'd1);
        check("d1_table", tab1, 8'h96);
        check("d1_pass", {7'd0, pass1}, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tt_scan.md
# tt_scan

Upstream stimulus-and-capture stage for the 3-input combinational SOP blocks. On a start pulse it steps `{a,b,c}` through all 8 combinations in ascending binary order. It holds each combination for a programmable dwell and samples the SOP output `y` into an 8-bit truth-table register. It then compares the result against an expected pattern and reports pass/fail with a busy/done handshake.

## Interface
Parameters:
- `DWELL`, default 2: clock cycles each combination is held; legal range 1..255.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  request a scan; sampled only in IDLE or DONE.
- `expected`  in  8  golden truth table; latched on the accepted `start`.
- `y`  in  1  output of the downstream SOP block under test.
- `a`, `b`, `c`  out  1 each  stimulus to the SOP block; `a` is the MSB of the combination index.
- `busy`  out  1  high while a scan is in progress.
- `done`  out  1  high from scan completion until the next accepted `start` or reset.
- `table_out`  out  8  captured truth table; bit `i` = `y` observed at `{a,b,c}==i`.
- `pass`  out  1  valid while `done`=1; 1 iff `table_out == expected`.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- IDLE, `start`=1: go to RUN, set idx=0 and dwell=0, clear `table_out` to 0, latch `expected`.
- RUN, dwell < DWELL-1: increment dwell.
- RUN, dwell == DWELL-1: write `table_out[idx]` <= `y` and reset dwell to 0.
  - If idx<7: increment idx.
  - If idx==7: go to DONE and compute `pass` from the final table, including the bit being written this edge.
- DONE, `start`=1: restart exactly as from IDLE and drop `done` and `pass`.
- DONE, `start`=0: hold all outputs.
- `{a,b,c}` = idx while in RUN, and 3'b000 in IDLE and DONE.
- `busy` = (state==RUN).
- `done` = (state==DONE).
- `start` while in RUN is ignored. There is no abort.
- idx is 3 bits; the scan ends at idx 7 and idx never wraps inside a scan.
- dwell counter is 8 bits.
- `y` is sampled with no synchroniser; the SOP block is combinational on the same clock domain.

## Timing
- Reset (`rst_n`=0 at a rising edge): state=IDLE, idx=0, dwell=0, `a`=`b`=`c`=0, `busy`=0, `done`=0, `pass`=0, `table_out`=8'h00, latched expected=8'h00.
- Reset mid-scan: abandon the scan and apply the same reset values. `done` is not asserted.
- Edge E0 accepts `start`. `busy` and `{a,b,c}`=000 are visible after E0.
- Combination k is driven during cycles E0+k·DWELL .. E0+(k+1)·DWELL-1.
- `y` for combination k is sampled at edge E0+(k+1)·DWELL, i.e. `y` settles for DWELL cycles before it is captured.
- At edge E0+8·DWELL: `busy` falls, `done` rises, and `pass` becomes valid in the same cycle.
- `busy` is high for exactly 8·DWELL cycles.
- Back-to-back scans: `start` held high in DONE is accepted on the first DONE cycle, so `done` is high for exactly one cycle.
- DWELL=1: one cycle per combination; total scan is 8 cycles.

## Test plan
- Reset and idle: hold `rst_n`=0 for 3 cycles, then release with `start`=0 for 5 cycles -> all outputs 0 throughout.
- Golden pass, DWELL=2: drive `y` = (a&b)|(~a&c) combinationally, `expected`=8'hCA, pulse `start` -> `busy` high 16 cycles, `{a,b,c}` steps 0..7 two cycles each, then `table_out`=8'hCA, `done`=1, `pass`=1.
- Mismatch: same `y`, `expected`=8'hCB -> `table_out`=8'hCA, `pass`=0, `done`=1.
- Start during RUN plus restart from DONE: pulse `start` at cycle 5 of a scan -> no effect, completion timing unchanged. Then hold `start` high in DONE -> `done` lasts 1 cycle, `table_out` reads 8'h00 during the new scan, and `expected` is re-latched.
- Reset mid-scan: assert `rst_n`=0 when idx=4 -> next cycle idx=0, `busy`=0, `table_out`=8'h00, and `done` stays 0 until a new scan completes.
- DWELL=1 with `y` = a^b^c -> scan completes 8 cycles after `start`, `table_out`=8'h96, `pass`=1 when `expected`=8'h96.
